// File: rtl/adder_tree_pkg.sv
// Shared widths, requester-id sizing and the tag carried alongside the adder tree.
// Pure declarations; no latency or backpressure of its own.
package adder_tree_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_LENGTH     = 8;
    localparam int DEFAULT_NUM_REQ    = 4;
    localparam int MAX_NUM_REQ        = 16;
    localparam int MAX_ID_WIDTH       = 4;

    // Requester id width, never narrower than one bit.
    function automatic int id_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    // Tag sized for the largest requester count so one type serves every instance.
    typedef struct packed {
        logic                    valid;
        logic [MAX_ID_WIDTH-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo NUM_REQ.
// Purely combinational, zero latency.
// No backpressure of its own; the caller decides whether the grant is used.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                any_grant
);

    localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);

    logic [ID_WIDTH:0]   pos;
    logic [ID_WIDTH-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        any_grant = 1'b0;
        pos       = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = {1'b0, ptr} + (ID_WIDTH+1)'(i);
            if (pos >= NUM_REQ_W) begin
                pos = pos - NUM_REQ_W;
            end
            idx = pos[ID_WIDTH-1:0];
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_tree_scheduler.sv
// Feeds one requester vector per cycle into an external adder tree and tags results with the requester id.
// Latency DELAY_STAGES cycles from transfer to res_valid; one vector per cycle throughput.
// A held result (res_valid && !res_ready) freezes the tree and tag pipe and withdraws all req_ready.
module adder_tree_scheduler
    import adder_tree_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int LENGTH       = DEFAULT_LENGTH,
    parameter int NUM_REQ      = DEFAULT_NUM_REQ,
    parameter int OUT_WIDTH    = DATA_WIDTH + $clog2(LENGTH),
    parameter int DELAY_STAGES = $clog2(LENGTH),
    parameter int ID_WIDTH     = id_width(NUM_REQ),
    parameter int CNT_WIDTH    = $clog2(DELAY_STAGES + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*LENGTH*DATA_WIDTH-1:0] req_addends,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic                                 flush,
    output logic                                 tree_advance,
    output logic [LENGTH*DATA_WIDTH-1:0]         tree_addends,
    input  logic [OUT_WIDTH-1:0]                 tree_sum,
    output logic                                 res_valid,
    output logic [ID_WIDTH-1:0]                  res_id,
    output logic [OUT_WIDTH-1:0]                 res_sum,
    input  logic                                 res_ready,
    output logic [CNT_WIDTH-1:0]                 inflight
);

    localparam int VEC_W = LENGTH * DATA_WIDTH;

    tag_t                tags [DELAY_STAGES];
    tag_t                head_tag;
    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] ptr_next;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_WIDTH-1:0] grant_id;
    logic                any_grant;
    logic                grant_en;
    logic                transfer;
    logic                res_pop;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_id  (grant_id),
        .any_grant (any_grant)
    );

    assign res_valid    = tags[DELAY_STAGES-1].valid;
    assign res_id       = tags[DELAY_STAGES-1].id[ID_WIDTH-1:0];
    assign res_sum      = tree_sum;
    assign res_pop      = res_valid && res_ready;
    assign tree_advance = !(res_valid && !res_ready);

    // Grants are withheld while stalled, flushing or held in reset.
    assign grant_en     = tree_advance && !flush && rst;
    assign req_ready    = grant & {NUM_REQ{grant_en}};
    assign transfer     = grant_en && any_grant;
    assign tree_addends = transfer ? req_addends[grant_id*VEC_W +: VEC_W] : '0;

    assign ptr_next = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        head_tag       = '0;
        head_tag.valid = transfer;
        head_tag.id    = MAX_ID_WIDTH'(grant_id);
    end

    // Tags shift in lockstep with the tree; flush only kills valids and wins over a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < DELAY_STAGES; s++) begin
                tags[s] <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < DELAY_STAGES; s++) begin
                tags[s].valid <= 1'b0;
            end
        end else if (tree_advance) begin
            tags[0] <= head_tag;
            for (int s = 1; s < DELAY_STAGES; s++) begin
                tags[s] <= tags[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= ptr_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else if (flush) begin
            inflight <= '0;
        end else if (transfer && !res_pop) begin
            inflight <= inflight + 1'b1;
        end else if (!transfer && res_pop) begin
            inflight <= inflight - 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_tree_scheduler.sv
// Bench for adder_tree_scheduler: external tree model, queue-based reference scoreboard,
// vector table, hand-written stall/flush/reset sequences and a randomized soak.
module tb_adder_tree_scheduler;

    localparam int DW        = 32;
    localparam int LENGTH    = 8;
    localparam int NUM_REQ   = 4;
    localparam int OUT_WIDTH = DW + $clog2(LENGTH);
    localparam int DSTAGES   = $clog2(LENGTH);
    localparam int IDW       = 2;
    localparam int CNTW      = $clog2(DSTAGES + 1);
    localparam int VW        = LENGTH * DW;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*VW-1:0]     req_addends;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      flush;
    logic                      tree_advance;
    logic [VW-1:0]             tree_addends;
    logic [OUT_WIDTH-1:0]      tree_sum;
    logic                      res_valid;
    logic [IDW-1:0]            res_id;
    logic [OUT_WIDTH-1:0]      res_sum;
    logic                      res_ready;
    logic [CNTW-1:0]           inflight;

    adder_tree_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addends  (req_addends),
        .req_ready    (req_ready),
        .flush        (flush),
        .tree_advance (tree_advance),
        .tree_addends (tree_addends),
        .tree_sum     (tree_sum),
        .res_valid    (res_valid),
        .res_id       (res_id),
        .res_sum      (res_sum),
        .res_ready    (res_ready),
        .inflight     (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic longint vsum(input logic [VW-1:0] v);
        longint acc = 0;
        for (int k = 0; k < LENGTH; k++) acc += longint'($signed(v[k*DW +: DW]));
        return acc;
    endfunction

    function automatic logic [VW-1:0] pack8(input longint a [LENGTH]);
        logic [VW-1:0] v = '0;
        for (int k = 0; k < LENGTH; k++) v[k*DW +: DW] = a[k][DW-1:0];
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h7fff_ffff;
            1:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_addends();
        for (int k = 0; k < NUM_REQ*LENGTH; k++) req_addends[k*DW +: DW] = rand_word();
    endtask

    // External adder tree: whole-vector sum delayed by DSTAGES advances.
    logic [OUT_WIDTH-1:0] ts [DSTAGES];
    always @(posedge clk) begin
        if (tree_advance) begin
            ts[0] <= OUT_WIDTH'(vsum(tree_addends));
            for (int s = 1; s < DSTAGES; s++) ts[s] <= ts[s-1];
        end
    end
    assign tree_sum = ts[DSTAGES-1];

    // Reference: queue of accepted vectors in order, each counting tree advances left before it shows.
    typedef struct packed {
        int     id;
        longint sum;
        int     left;
    } ent_t;

    ent_t               q [$];
    int                 m_ptr = 0;
    bit                 mon_en = 0;
    bit                 m_rv;
    bit                 m_adv;
    int                 m_gid;
    int                 m_j;
    logic [NUM_REQ-1:0] m_gnt;
    ent_t               m_ent;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst) begin
                q.delete();
                m_ptr = 0;
            end else begin
                m_rv  = (q.size() > 0) && (q[0].left == 0);
                m_adv = !(m_rv && !res_ready);
                chk("mon_inflight", longint'(inflight), longint'(q.size()));
                chk("mon_res_valid", longint'(res_valid), longint'(m_rv));
                chk("mon_tree_advance", longint'(tree_advance), longint'(m_adv));
                m_gnt = '0;
                m_gid = -1;
                if (m_adv && !flush) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        m_j = (m_ptr + k) % NUM_REQ;
                        if (m_gid < 0 && req_valid[m_j]) begin
                            m_gid      = m_j;
                            m_gnt[m_j] = 1'b1;
                        end
                    end
                end
                chk("mon_req_ready", longint'(req_ready), longint'(m_gnt));
                if (m_rv) begin
                    chk("mon_res_id", longint'(res_id), longint'(q[0].id));
                    chk("mon_res_sum", longint'($signed(res_sum)), q[0].sum);
                end
                if (m_rv && res_ready) void'(q.pop_front());
                if (flush) begin
                    q.delete();
                end else if (m_adv) begin
                    foreach (q[k]) if (q[k].left > 0) q[k].left = q[k].left - 1;
                end
                if (m_gid >= 0) begin
                    m_ent.id   = m_gid;
                    m_ent.sum  = vsum(req_addends[m_gid*VW +: VW]);
                    m_ent.left = DSTAGES - 1;
                    q.push_back(m_ent);
                    m_ptr = (m_gid + 1) % NUM_REQ;
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        req_valid = '0;
        flush     = 1'b0;
        res_ready = 1'b1;
        while (inflight != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_inflight", longint'(inflight), 0);
    endtask

    typedef struct packed {
        int            rid;
        logic [VW-1:0] vec;
        longint        exp_sum;
    } tv_t;

    tv_t                tbl [4];
    longint             tmp [LENGTH];
    logic [NUM_REQ-1:0] exp_oh;
    int                 lat;
    int                 gid;
    longint             first_sum;

    initial begin
        tmp = '{123, -387, -1468, 1189, 4396, -231, 666, 999};
        tbl[0] = '{rid: 0, vec: pack8(tmp), exp_sum: 64'sd5287};
        tmp = '{default: -1};
        tbl[1] = '{rid: 2, vec: pack8(tmp), exp_sum: -64'sd8};
        tmp = '{default: -2147483647 - 1};
        tbl[2] = '{rid: 1, vec: pack8(tmp), exp_sum: -64'sd17179869184};
        tmp = '{default: 2147483647};
        tbl[3] = '{rid: 3, vec: pack8(tmp), exp_sum: 64'sd17179869176};

        // Reset: requests present but never accepted.
        rst         = 1'b0;
        req_valid   = '1;
        req_addends = '0;
        randomize_addends();
        flush       = 1'b0;
        res_ready   = 1'b1;
        #12;
        chk("rst_res_valid", longint'(res_valid), 0);
        chk("rst_req_ready", longint'(req_ready), 0);
        chk("rst_tree_advance", longint'(tree_advance), 1);
        chk("rst_tree_addends_zero", longint'(tree_addends != '0), 0);
        chk("rst_inflight", longint'(inflight), 0);
        @(posedge clk);
        #2;
        req_valid = '0;
        rst       = 1'b1;
        mon_en    = 1'b1;
        tick();

        // Table of single-request vectors with known sums.
        for (int t = 0; t < 4; t++) begin
            req_addends = '0;
            req_addends[tbl[t].rid*VW +: VW] = tbl[t].vec;
            exp_oh = '0;
            exp_oh[tbl[t].rid] = 1'b1;
            req_valid = exp_oh;
            #3;
            chk("tbl_req_ready", longint'(req_ready), longint'(exp_oh));
            tick();
            req_valid = '0;
            lat = 1;
            #3;
            while (!res_valid && lat < 10) begin
                tick();
                #3;
                lat++;
            end
            chk("tbl_latency", lat, DSTAGES);
            chk("tbl_res_id", longint'(res_id), tbl[t].rid);
            chk("tbl_res_sum", longint'($signed(res_sum)), tbl[t].exp_sum);
            tick();
        end
        drain();

        // Round-robin with every requester asserting continuously.
        randomize_addends();
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #3;
            gid = -1;
            for (int b = 0; b < NUM_REQ; b++) if (req_ready[b]) gid = b;
            chk("rr_grant", gid, k % NUM_REQ);
            tick();
        end
        drain();

        // Backpressure: three accepted, consumer stalls for five cycles.
        res_ready = 1'b0;
        req_valid = 4'b0001;
        randomize_addends();
        first_sum = vsum(req_addends[0 +: VW]);
        for (int k = 0; k < 3; k++) begin
            tick();
            randomize_addends();
        end
        for (int k = 0; k < 5; k++) begin
            #3;
            chk("bp_tree_advance", longint'(tree_advance), 0);
            chk("bp_req_ready", longint'(req_ready), 0);
            chk("bp_res_valid", longint'(res_valid), 1);
            chk("bp_res_id", longint'(res_id), 0);
            chk("bp_res_sum", longint'($signed(res_sum)), first_sum);
            chk("bp_inflight", longint'(inflight), 3);
            tick();
        end
        drain();

        // Flush with two in flight; pointer must survive.
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0100;
        tick();
        flush     = 1'b1;
        req_valid = '1;
        #3;
        chk("fl_req_ready", longint'(req_ready), 0);
        chk("fl_inflight_before", longint'(inflight), 2);
        tick();
        flush = 1'b0;
        #3;
        chk("fl_inflight_after", longint'(inflight), 0);
        chk("fl_res_valid_after", longint'(res_valid), 0);
        chk("fl_ptr_kept", longint'(req_ready), 4'b1000);
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            #3;
            chk("fl_no_result", longint'(res_valid), 0);
        end
        drain();

        // Asynchronous reset in the middle of a stream.
        req_valid = '1;
        randomize_addends();
        for (int k = 0; k < 4; k++) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_res_valid", longint'(res_valid), 0);
        chk("arst_inflight", longint'(inflight), 0);
        chk("arst_req_ready", longint'(req_ready), 0);
        chk("arst_tree_advance", longint'(tree_advance), 1);
        tick();
        #1;
        rst = 1'b1;
        #2;
        chk("arst_first_grant", longint'(req_ready), 4'b0001);
        tick();
        drain();

        // Randomized soak against the scoreboard.
        for (int c = 0; c < 1500; c++) begin
            req_valid = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            randomize_addends();
            res_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            tick();
        end
        drain();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adder_tree_scheduler.md
ADDER_TREE_SCHEDULER -- requirements
Module: adder_tree_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one signed addend.
REQ-002 SHALL have parameter LENGTH, default 8, addends per vector.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-004 SHALL have derived parameters OUT_WIDTH=DATA_WIDTH+clog2(LENGTH), DELAY_STAGES=clog2(LENGTH), ID_WIDTH=max(1,clog2(NUM_REQ)).
REQ-005 SHALL have clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have req_valid  in  NUM_REQ  per-requester vector valid.
REQ-008 SHALL have req_addends  in  NUM_REQ*LENGTH*DATA_WIDTH  requester i at slice i.
REQ-009 SHALL have req_ready  out  NUM_REQ  one-hot-or-zero accept.
REQ-010 SHALL have flush  in  1  synchronous discard of all in-flight tags.
REQ-011 SHALL have tree_advance  out  1  pipeline enable to the shared adder tree.
REQ-012 SHALL have tree_addends  out  LENGTH*DATA_WIDTH  vector driven into the tree.
REQ-013 SHALL have tree_sum  in  OUT_WIDTH  tree output, valid DELAY_STAGES advances after input.
REQ-014 SHALL have res_valid, res_id (ID_WIDTH), res_sum (OUT_WIDTH)  out  result channel.
REQ-015 SHALL have res_ready  in  1  result consumer accept.
REQ-016 SHALL have inflight  out  clog2(DELAY_STAGES+1)  count of valid tags in pipe.

Function
REQ-017 SHALL keep a tag pipe of DELAY_STAGES entries {valid,id}, shifting only when tree_advance=1, in lockstep with the tree.
REQ-018 SHALL drive res_valid/res_id from the tail tag and res_sum=tree_sum combinationally.
REQ-019 SHALL set tree_advance = !(res_valid && !res_ready); stalled pipe holds all tags and res_* stable.
REQ-020 SHALL grant at most one requester per cycle, only when tree_advance=1; req_ready[i]=grant[i]&tree_advance; transfer occurs when req_valid[i]&req_ready[i].
REQ-021 SHALL arbitrate round-robin: search starts at ptr, ptr updates to (granted id+1) mod NUM_REQ on transfer only.
REQ-022 SHALL drive tree_addends = granted requester slice, all-zero when no grant; head tag gets valid=transfer, id=granted id.
REQ-023 SHALL give latency DELAY_STAGES cycles from transfer to res_valid with no stall; throughput one vector/cycle.
REQ-024 SHALL not depend on req_ready to assert req_valid (no combinational valid->ready loop beyond arbitration).
REQ-025 SHALL on flush clear all tag valid bits next edge, accept no request that cycle, keep ptr; flush overrides stall.
REQ-026 SHALL maintain inflight: +1 on transfer, -1 on res_valid&res_ready, both -> unchanged; zero on flush.
REQ-027 SHALL treat sums as two's-complement, no saturation; OUT_WIDTH guarantees no overflow.

Reset
REQ-028 SHALL on rst low asynchronously clear tag valids, ids, ptr and inflight to 0; res_valid=0, req_ready=0, tree_advance=1, tree_addends=0.
REQ-029 SHALL resume arbitration on the first rising edge after rst deasserts; requests during reset are not accepted.

Structure
REQ-030 SHALL place default widths, ID_WIDTH derivation and the tag struct {valid,id} in shared package adder_tree_pkg.
REQ-031 SHALL implement arbitration in sub-module rr_arbiter (req, ptr -> one-hot grant, id); tree itself stays external.

Verification
REQ-032 SHALL cover single request: req 0 with {123,-387,-1468,1189,4396,-231,666,999}, res_ready=1 -> res_valid after 3 cycles, res_id=0, res_sum=5287 (35'h14A7).
REQ-033 SHALL cover round-robin: all 4 valid continuously -> grants 0,1,2,3,0 on consecutive cycles, res_id in same order.
REQ-034 SHALL cover backpressure: res_ready=0 for 5 cycles with 3 in flight -> tree_advance=0, req_ready=0, res_* stable, inflight=3; release drains in order.
REQ-035 SHALL cover flush with 2 in flight -> next cycle inflight=0, no res_valid for those tags, ptr unchanged.
REQ-036 SHALL cover async reset mid-stream (rst low between edges) -> res_valid and inflight 0 immediately, first post-reset grant to requester 0.
